// File: rtl/nanci_shear_pe_if.sv
// Per-cell port bundle for the Nanci shear-sort PE: load/start control,
// the four neighbour element inputs and the element/status outputs.
interface nanci_shear_pe_if #(
    parameter int W = 6
);
    logic         i_load;
    logic [W-1:0] i_load_data;
    logic         i_start;
    logic [W-1:0] i_PE_l;
    logic [W-1:0] i_PE_r;
    logic [W-1:0] i_PE_u;
    logic [W-1:0] i_PE_d;
    logic [W-1:0] o_PE;
    logic         o_busy;
    logic         o_done;

    modport master (
        output i_load, i_load_data, i_start,
        output i_PE_l, i_PE_r, i_PE_u, i_PE_d,
        input  o_PE, o_busy, o_done
    );

    modport slave (
        input  i_load, i_load_data, i_start,
        input  i_PE_l, i_PE_r, i_PE_u, i_PE_d,
        output o_PE, o_busy, o_done
    );
endinterface

// File: rtl/nanci_shear_pe.sv
// Shear-sort mesh cell: holds one {key, payload} element and runs the full
// snake row / column odd-even transposition schedule after a start pulse.
//
// state   | meaning
// IDLE    | waiting; load or start accepted
// SORT    | one compare-exchange step per cycle, t/p counters advancing
// DONE    | schedule finished, element held; load or start accepted
module nanci_shear_pe #(
    parameter int KEY_WIDTH = 3,
    parameter int VAL_WIDTH = 3,
    parameter int N         = 4,
    parameter int ROW       = 0,
    parameter int COL       = 0,
    parameter int ROUNDS    = 3
) (
    input  logic            clk,
    input  logic            rst,
    nanci_shear_pe_if.slave pe
);
    localparam int W  = KEY_WIDTH + VAL_WIDTH;
    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = ((2 * ROUNDS) > 1) ? $clog2(2 * ROUNDS) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(N - 1);
    localparam logic [PW-1:0] P_LAST = PW'(2 * ROUNDS - 2);

    localparam bit HAS_L   = (COL > 0);
    localparam bit HAS_R   = (COL < N - 1);
    localparam bit HAS_U   = (ROW > 0);
    localparam bit HAS_D   = (ROW < N - 1);
    localparam bit COL_ODD = ((COL % 2) == 1);
    localparam bit ROW_ODD = ((ROW % 2) == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   e_q;
    logic [W-1:0]   e_d;
    logic [TW-1:0]  t_q;
    logic [PW-1:0]  p_q;
    logic           busy_q;
    logic           done_q;

    logic [W-1:0]         partner;
    logic                 has_partner;
    logic                 want_smaller;
    logic [KEY_WIDTH-1:0] part_key;
    logic [KEY_WIDTH-1:0] my_key;

    // Partner selection: pair parity comes from the step index plus this cell's
    // coordinate; want_smaller marks the cell that should end up with the lower key.
    always_comb begin
        partner      = '0;
        has_partner  = 1'b0;
        want_smaller = 1'b0;
        if (!p_q[0]) begin
            if (t_q[0] == COL_ODD) begin
                has_partner  = HAS_R;
                partner      = pe.i_PE_r;
                want_smaller = !ROW_ODD;
            end else begin
                has_partner  = HAS_L;
                partner      = pe.i_PE_l;
                want_smaller = ROW_ODD;
            end
        end else begin
            if (t_q[0] == ROW_ODD) begin
                has_partner  = HAS_D;
                partner      = pe.i_PE_d;
                want_smaller = 1'b1;
            end else begin
                has_partner  = HAS_U;
                partner      = pe.i_PE_u;
                want_smaller = 1'b0;
            end
        end
    end

    assign part_key = partner[W-1 -: KEY_WIDTH];
    assign my_key   = e_q[W-1 -: KEY_WIDTH];

    // Strict compares keep equal keys in place, so payload order is stable.
    always_comb begin
        e_d = e_q;
        if (has_partner) begin
            if (want_smaller ? (part_key < my_key) : (part_key > my_key)) begin
                e_d = partner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            e_q     <= '0;
            t_q     <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (pe.i_load) begin
                        e_q     <= pe.i_load_data;
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end else if (pe.i_start) begin
                        state_q <= ST_SORT;
                        t_q     <= '0;
                        p_q     <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_SORT: begin
                    e_q <= e_d;
                    if (t_q == T_LAST) begin
                        t_q <= '0;
                        if (p_q == P_LAST) begin
                            p_q     <= '0;
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            p_q <= p_q + 1'b1;
                        end
                    end else begin
                        t_q <= t_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pe.o_PE   = e_q;
    assign pe.o_busy = busy_q;
    assign pe.o_done = done_q;

endmodule

// File: tb/tb_nanci_shear_pe.sv
// Bench for nanci_shear_pe: a 2x2 mesh, a 1x2 single-row pair and a lone
// N=1 cell, checked against a queue of expected elements.
module tb_nanci_shear_pe;
    logic clk;
    logic rst;

    int n_vec;
    int n_miss;
    logic [5:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 2x2 mesh ----------------
    logic       mesh_load;
    logic       mesh_start;
    logic [5:0] mesh_data [4];
    logic [5:0] mesh_out  [4];

    nanci_shear_pe_if #(.W(6)) m00 ();
    nanci_shear_pe_if #(.W(6)) m01 ();
    nanci_shear_pe_if #(.W(6)) m10 ();
    nanci_shear_pe_if #(.W(6)) m11 ();

    assign m00.i_load = mesh_load;  assign m00.i_start = mesh_start;  assign m00.i_load_data = mesh_data[0];
    assign m01.i_load = mesh_load;  assign m01.i_start = mesh_start;  assign m01.i_load_data = mesh_data[1];
    assign m10.i_load = mesh_load;  assign m10.i_start = mesh_start;  assign m10.i_load_data = mesh_data[2];
    assign m11.i_load = mesh_load;  assign m11.i_start = mesh_start;  assign m11.i_load_data = mesh_data[3];

    assign m00.i_PE_l = '0;         assign m00.i_PE_r = m01.o_PE;   assign m00.i_PE_u = '0;         assign m00.i_PE_d = m10.o_PE;
    assign m01.i_PE_l = m00.o_PE;   assign m01.i_PE_r = '0;         assign m01.i_PE_u = '0;         assign m01.i_PE_d = m11.o_PE;
    assign m10.i_PE_l = '0;         assign m10.i_PE_r = m11.o_PE;   assign m10.i_PE_u = m00.o_PE;   assign m10.i_PE_d = '0;
    assign m11.i_PE_l = m10.o_PE;   assign m11.i_PE_r = '0;         assign m11.i_PE_u = m01.o_PE;   assign m11.i_PE_d = '0;

    assign mesh_out[0] = m00.o_PE;
    assign mesh_out[1] = m01.o_PE;
    assign mesh_out[2] = m10.o_PE;
    assign mesh_out[3] = m11.o_PE;

    nanci_shear_pe #(.KEY_WIDTH(3), .VAL_WIDTH(3), .N(2), .ROW(0), .COL(0), .ROUNDS(2)) u_m00 (.clk(clk), .rst(rst), .pe(m00));
    nanci_shear_pe #(.KEY_WIDTH(3), .VAL_WIDTH(3), .N(2), .ROW(0), .COL(1), .ROUNDS(2)) u_m01 (.clk(clk), .rst(rst), .pe(m01));
    nanci_shear_pe #(.KEY_WIDTH(3), .VAL_WIDTH(3), .N(2), .ROW(1), .COL(0), .ROUNDS(2)) u_m10 (.clk(clk), .rst(rst), .pe(m10));
    nanci_shear_pe #(.KEY_WIDTH(3), .VAL_WIDTH(3), .N(2), .ROW(1), .COL(1), .ROUNDS(2)) u_m11 (.clk(clk), .rst(rst), .pe(m11));

    // ---------------- 1x2 row, one row phase ----------------
    logic       pair_load;
    logic       pair_start;
    logic [5:0] pair_data [2];

    nanci_shear_pe_if #(.W(6)) p0 ();
    nanci_shear_pe_if #(.W(6)) p1 ();

    assign p0.i_load = pair_load;  assign p0.i_start = pair_start;  assign p0.i_load_data = pair_data[0];
    assign p1.i_load = pair_load;  assign p1.i_start = pair_start;  assign p1.i_load_data = pair_data[1];
    assign p0.i_PE_l = '0;  assign p0.i_PE_r = p1.o_PE;  assign p0.i_PE_u = '0;  assign p0.i_PE_d = '0;
    assign p1.i_PE_l = p0.o_PE;  assign p1.i_PE_r = '0;  assign p1.i_PE_u = '0;  assign p1.i_PE_d = '0;

    nanci_shear_pe #(.KEY_WIDTH(3), .VAL_WIDTH(3), .N(2), .ROW(0), .COL(0), .ROUNDS(1)) u_p0 (.clk(clk), .rst(rst), .pe(p0));
    nanci_shear_pe #(.KEY_WIDTH(3), .VAL_WIDTH(3), .N(2), .ROW(0), .COL(1), .ROUNDS(1)) u_p1 (.clk(clk), .rst(rst), .pe(p1));

    // ---------------- single N=1 cell ----------------
    logic       s_load;
    logic       s_start;
    logic [5:0] s_data;

    nanci_shear_pe_if #(.W(6)) s0 ();
    assign s0.i_load = s_load;  assign s0.i_start = s_start;  assign s0.i_load_data = s_data;
    assign s0.i_PE_l = '0;  assign s0.i_PE_r = '0;  assign s0.i_PE_u = '0;  assign s0.i_PE_d = '0;

    nanci_shear_pe #(.KEY_WIDTH(3), .VAL_WIDTH(3), .N(1), .ROW(0), .COL(0), .ROUNDS(3)) u_s0 (.clk(clk), .rst(rst), .pe(s0));

    // ---------------- stimulus helpers ----------------
    task automatic load_mesh(input logic [5:0] d0, input logic [5:0] d1,
                             input logic [5:0] d2, input logic [5:0] d3);
        @(negedge clk);
        mesh_data[0] = d0; mesh_data[1] = d1; mesh_data[2] = d2; mesh_data[3] = d3;
        mesh_load = 1'b1;
        @(negedge clk);
        mesh_load = 1'b0;
    endtask

    // Pulses start and counts edges until busy drops; optionally injects
    // load/start mid-sort, which the cells must ignore.
    task automatic run_mesh(input bit inject, output int cycles);
        @(negedge clk);
        mesh_start = 1'b1;
        @(negedge clk);
        mesh_start = 1'b0;
        cycles = 0;
        while (m00.o_busy === 1'b1 && cycles < 200) begin
            if (inject && cycles == 2) begin
                mesh_data[0] = 6'b111111; mesh_data[1] = 6'b111111;
                mesh_data[2] = 6'b111111; mesh_data[3] = 6'b111111;
                mesh_load  = 1'b1;
                mesh_start = 1'b1;
            end else begin
                mesh_load  = 1'b0;
                mesh_start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        mesh_load  = 1'b0;
        mesh_start = 1'b0;
    endtask

    task automatic run_single(output int cycles);
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cycles = 0;
        while (s0.o_busy === 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int cyc;
        n_vec++;
        if ({m00.o_busy, m00.o_done, s0.o_busy, s0.o_done} !== 4'b0000) begin
            n_miss++;
            $display("FAIL reset_flags: got %b want 0000", {m00.o_busy, m00.o_done, s0.o_busy, s0.o_done});
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mesh_out[i] !== 6'd0) begin
                n_miss++;
                $display("FAIL reset_pe[%0d]: got %b want 000000", i, mesh_out[i]);
            end
        end
        load_mesh(6'o30, 6'o11, 6'o02, 6'o23);
        @(negedge clk);
        mesh_start = 1'b1;
        @(negedge clk);
        mesh_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({m00.o_busy, m00.o_done, m11.o_busy} !== 3'b000) begin
            n_miss++;
            $display("FAIL midsort_reset_flags: got %b want 000", {m00.o_busy, m00.o_done, m11.o_busy});
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mesh_out[i] !== 6'd0) begin
                n_miss++;
                $display("FAIL midsort_reset_pe[%0d]: got %b want 000000", i, mesh_out[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({m00.o_busy, m00.o_done, mesh_out[0]} !== 8'd0) begin
            n_miss++;
            $display("FAIL post_reset_idle: got busy=%b done=%b pe=%b want 0 0 0",
                     m00.o_busy, m00.o_done, mesh_out[0]);
        end
        cyc = 0;
    endtask

    task automatic test_mesh_basic(input bit inject);
        int cyc;
        logic [5:0] exp;
        load_mesh(6'o30, 6'o11, 6'o02, 6'o23);
        exp_q.push_back(6'o02);
        exp_q.push_back(6'o11);
        exp_q.push_back(6'o30);
        exp_q.push_back(6'o23);
        run_mesh(inject, cyc);
        n_vec++;
        if (cyc !== 6) begin
            n_miss++;
            $display("FAIL mesh_latency(inject=%0d): got %0d want 6", inject, cyc);
        end
        n_vec++;
        if ({m00.o_done, m11.o_done, m00.o_busy} !== 3'b110) begin
            n_miss++;
            $display("FAIL mesh_done(inject=%0d): got %b want 110", inject, {m00.o_done, m11.o_done, m00.o_busy});
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            n_vec++;
            if (mesh_out[i] !== exp) begin
                n_miss++;
                $display("FAIL mesh_result[%0d](inject=%0d): got %b want %b", i, inject, mesh_out[i], exp);
            end
        end
    endtask

    task automatic test_mesh_random;
        int perm[8];
        int j, tmp, cyc;
        logic [5:0] el[4];
        logic [5:0] t6;
        logic [5:0] exp;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int i = 0; i < 4; i++) el[i] = {perm[i][2:0], 3'($urandom_range(7, 0))};
            load_mesh(el[0], el[1], el[2], el[3]);
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < 3 - a; b++)
                    if (el[b][5:3] > el[b+1][5:3]) begin
                        t6 = el[b]; el[b] = el[b+1]; el[b+1] = t6;
                    end
            exp_q.push_back(el[0]);
            exp_q.push_back(el[1]);
            exp_q.push_back(el[3]);
            exp_q.push_back(el[2]);
            run_mesh(1'b0, cyc);
            n_vec++;
            if (cyc !== 6) begin
                n_miss++;
                $display("FAIL rand_latency[%0d]: got %0d want 6", r, cyc);
            end
            for (int i = 0; i < 4; i++) begin
                exp = exp_q.pop_front();
                n_vec++;
                if (mesh_out[i] !== exp) begin
                    n_miss++;
                    $display("FAIL rand_result[%0d][%0d]: got %b want %b", r, i, mesh_out[i], exp);
                end
            end
        end
    endtask

    task automatic test_done_clear;
        int cyc;
        logic [5:0] exp;
        for (int i = 0; i < 4; i++) exp_q.push_back(mesh_out[i] === 6'bx ? 6'd0 : 6'd0);
        for (int i = 0; i < 4; i++) void'(exp_q.pop_front());
        load_mesh(6'o30, 6'o11, 6'o02, 6'o23);
        run_mesh(1'b0, cyc);
        // a second start straight from DONE re-runs the full schedule on sorted data
        exp_q.push_back(6'o02);
        exp_q.push_back(6'o11);
        exp_q.push_back(6'o30);
        exp_q.push_back(6'o23);
        run_mesh(1'b0, cyc);
        n_vec++;
        if (cyc !== 6) begin
            n_miss++;
            $display("FAIL restart_latency: got %0d want 6", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            n_vec++;
            if (mesh_out[i] !== exp) begin
                n_miss++;
                $display("FAIL restart_result[%0d]: got %b want %b", i, mesh_out[i], exp);
            end
        end
        load_mesh(6'o01, 6'o02, 6'o03, 6'o04);
        n_vec++;
        if ({m00.o_done, m00.o_busy, mesh_out[3]} !== {2'b00, 6'o04}) begin
            n_miss++;
            $display("FAIL done_clear_on_load: got done=%b busy=%b pe3=%b want 0 0 000100",
                     m00.o_done, m00.o_busy, mesh_out[3]);
        end
    endtask

    task automatic test_tie;
        int cyc;
        logic [5:0] exp;
        logic [5:0] vecs [4];
        vecs[0] = 6'b101001; vecs[1] = 6'b101110;
        vecs[2] = 6'b110001; vecs[3] = 6'b010011;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            pair_data[0] = vecs[2*k];
            pair_data[1] = vecs[2*k+1];
            pair_load = 1'b1;
            @(negedge clk);
            pair_load = 1'b0;
            if (vecs[2*k][5:3] > vecs[2*k+1][5:3]) begin
                exp_q.push_back(vecs[2*k+1]);
                exp_q.push_back(vecs[2*k]);
            end else begin
                exp_q.push_back(vecs[2*k]);
                exp_q.push_back(vecs[2*k+1]);
            end
            pair_start = 1'b1;
            @(negedge clk);
            pair_start = 1'b0;
            cyc = 0;
            while (p0.o_busy === 1'b1 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            n_vec++;
            if ({cyc[7:0], p1.o_done} !== {8'd2, 1'b1}) begin
                n_miss++;
                $display("FAIL pair_latency[%0d]: got %0d done=%b want 2 done=1", k, cyc, p1.o_done);
            end
            exp = exp_q.pop_front();
            n_vec++;
            if (p0.o_PE !== exp) begin
                n_miss++;
                $display("FAIL pair_left[%0d]: got %b want %b", k, p0.o_PE, exp);
            end
            exp = exp_q.pop_front();
            n_vec++;
            if (p1.o_PE !== exp) begin
                n_miss++;
                $display("FAIL pair_right[%0d]: got %b want %b", k, p1.o_PE, exp);
            end
        end
    endtask

    task automatic test_single;
        int cyc;
        logic [5:0] exp;
        @(negedge clk);
        s_data = 6'b101011;
        s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        exp_q.push_back(6'b101011);
        run_single(cyc);
        n_vec++;
        if (cyc !== 5) begin
            n_miss++;
            $display("FAIL single_latency: got %0d want 5", cyc);
        end
        exp = exp_q.pop_front();
        n_vec++;
        if ({s0.o_done, s0.o_PE} !== {1'b1, exp}) begin
            n_miss++;
            $display("FAIL single_result: got done=%b pe=%b want 1 %b", s0.o_done, s0.o_PE, exp);
        end
    endtask

    task automatic test_load_start_same_cycle;
        int cyc;
        logic [5:0] exp;
        @(negedge clk);
        s_data  = 6'b010110;
        s_load  = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_load  = 1'b0;
        s_start = 1'b0;
        exp_q.push_back(6'b010110);
        n_vec++;
        if ({s0.o_busy, s0.o_done} !== 2'b00) begin
            n_miss++;
            $display("FAIL load_wins_flags: got busy=%b done=%b want 0 0", s0.o_busy, s0.o_done);
        end
        @(negedge clk);
        n_vec++;
        if (s0.o_busy !== 1'b0) begin
            n_miss++;
            $display("FAIL load_wins_no_sort: got busy=%b want 0", s0.o_busy);
        end
        run_single(cyc);
        n_vec++;
        if (cyc !== 5) begin
            n_miss++;
            $display("FAIL later_start_latency: got %0d want 5", cyc);
        end
        exp = exp_q.pop_front();
        n_vec++;
        if (s0.o_PE !== exp) begin
            n_miss++;
            $display("FAIL load_wins_value: got %b want %b", s0.o_PE, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b0;
        mesh_load = 1'b0; mesh_start = 1'b0;
        pair_load = 1'b0; pair_start = 1'b0;
        s_load = 1'b0; s_start = 1'b0; s_data = '0;
        for (int i = 0; i < 4; i++) mesh_data[i] = '0;
        pair_data[0] = '0; pair_data[1] = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_mesh_basic(1'b0);
        test_mesh_basic(1'b1);
        test_mesh_random;
        test_done_clear;
        test_tie;
        test_single;
        test_load_start_same_cycle;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
